// File: rtl/bht_controller.sv
// Branch history table: 32 two-bit saturating counters with init walk,
// one-cycle lookup and same-cycle read-before-write update.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   clear          re-initialise the table (honoured only in RUN)
//   ready          high in RUN; lookups/updates accepted only then
//   lookup_valid, lookup_index   lookup request and entry to read
//   predict_valid  one-cycle pulse after an accepted lookup
//   predict_taken  MSB of the looked-up counter, held until next lookup
//   update_valid, update_index, update_taken   resolved-branch update
module bht_controller #(
   parameter logic [1:0] INIT_VAL = 2'b01
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   output logic       ready,
   input  logic       lookup_valid,
   input  logic [4:0] lookup_index,
   output logic       predict_valid,
   output logic       predict_taken,
   input  logic       update_valid,
   input  logic [4:0] update_index,
   input  logic       update_taken
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t     state, state_n;
   logic [4:0] ptr, ptr_n;
   logic [1:0] cnt [32];
   logic       lkp_go, upd_go;
   logic [1:0] upd_cur, upd_nxt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_INIT;
         ptr   <= 5'd0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      unique case (state)
         S_INIT: begin
            ptr_n = ptr + 5'd1;
            if (ptr == 5'd31) state_n = S_RUN;
         end
         S_RUN: begin
            if (clear) begin
               state_n = S_INIT;
               ptr_n   = 5'd0;
            end
         end
         default: begin
            state_n = S_INIT;
            ptr_n   = 5'd0;
         end
      endcase
   end

   assign ready = (state == S_RUN);

   // clear takes priority over any request in the same cycle
   assign lkp_go = ready && lookup_valid && !clear;
   assign upd_go = ready && update_valid && !clear;

   assign upd_cur = cnt[update_index];

   always_comb begin
      upd_nxt = upd_cur;
      if (update_taken) begin
         if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'd1;
      end else begin
         if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'd1;
      end
   end

   // counter contents are not reset; the INIT walk rewrites them
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == S_INIT)
            cnt[ptr] <= INIT_VAL;
         else if (upd_go)
            cnt[update_index] <= upd_nxt;
      end
   end

   // the read uses the pre-edge table, so a same-index update
   // is not yet visible (read-before-write)
   always_ff @(posedge clock) begin
      if (reset) begin
         predict_valid <= 1'b0;
         predict_taken <= 1'b0;
      end else begin
         predict_valid <= lkp_go;
         if (lkp_go) predict_taken <= cnt[lookup_index][1];
      end
   end

endmodule

// File: tb/tb_bht_controller.sv
// Scoreboard bench for bht_controller: a high-level table model predicts
// ready and every prediction; a monitor compares on each falling edge.
module tb_bht_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       ready;
   logic       lookup_valid = 1'b0;
   logic [4:0] lookup_index = 5'd0;
   logic       predict_valid;
   logic       predict_taken;
   logic       update_valid = 1'b0;
   logic [4:0] update_index = 5'd0;
   logic       update_taken = 1'b0;

   bht_controller dut (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear),
      .ready         (ready),
      .lookup_valid  (lookup_valid),
      .lookup_index  (lookup_index),
      .predict_valid (predict_valid),
      .predict_taken (predict_taken),
      .update_valid  (update_valid),
      .update_index  (update_index),
      .update_taken  (update_taken)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   int mdl [32];
   int init_left = 32;
   bit exp_ready = 1'b0;
   bit exp_q [$];

   // Model of one rising edge given the inputs about to be sampled.
   task automatic model_step(input bit rst, input bit clr,
                             input bit lv, input int li,
                             input bit uv, input int ui, input bit ut);
      if (rst) begin
         init_left = 32;
         exp_ready = 1'b0;
         for (int i = 0; i < 32; i++) mdl[i] = 1;
      end else if (!exp_ready) begin
         init_left = init_left - 1;
         if (init_left == 0) exp_ready = 1'b1;
      end else if (clr) begin
         init_left = 32;
         exp_ready = 1'b0;
         for (int i = 0; i < 32; i++) mdl[i] = 1;
      end else begin
         if (lv) exp_q.push_back(mdl[li] >= 2);
         if (uv) begin
            if (ut) mdl[ui] = (mdl[ui] == 3) ? 3 : mdl[ui] + 1;
            else    mdl[ui] = (mdl[ui] == 0) ? 0 : mdl[ui] - 1;
         end
      end
   endtask

   task automatic cyc(input bit rst, input bit clr,
                      input bit lv, input int li,
                      input bit uv, input int ui, input bit ut);
      @(negedge clock);
      #1;
      reset        = rst;
      clear        = clr;
      lookup_valid = lv;
      lookup_index = li[4:0];
      update_valid = uv;
      update_index = ui[4:0];
      update_taken = ut;
      model_step(rst, clr, lv, li, uv, ui, ut);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic backdoor();
      @(posedge clock);
      #1;
      for (int i = 0; i < 32; i++) begin
         n_cmp++;
         if (int'(dut.cnt[i]) != mdl[i]) begin
            n_bad++;
            $display("FAIL backdoor cnt[%0d] got %0d want %0d",
                     i, dut.cnt[i], mdl[i]);
         end
      end
   endtask

   // monitor: ready every cycle, predictions against the queue
   initial begin
      forever begin
         @(negedge clock);
         n_cmp++;
         if (ready !== exp_ready) begin
            n_bad++;
            $display("FAIL ready got %b want %b at %0t",
                     ready, exp_ready, $time);
         end
         if (predict_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected predict_valid got 1 want 0 at %0t",
                        $time);
            end else begin
               bit e;
               e = exp_q.pop_front();
               if (predict_taken !== e) begin
                  n_bad++;
                  $display("FAIL predict_taken got %b want %b at %0t",
                           predict_taken, e, $time);
               end
            end
         end else if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing predict_valid got %b want 1 at %0t",
                     predict_valid, $time);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 1;

      // reset and init, with lookups and updates during INIT
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #2;
      n_cmp++;
      if (predict_taken !== 1'b0 || predict_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset outputs got %b%b want 00",
                  predict_valid, predict_taken);
      end
      for (int i = 0; i < 32; i++) cyc(0, 0, 1, i, 1, i, 1);
      for (int i = 0; i < 32; i++) cyc(0, 0, 1, i, 0, 0, 0);
      backdoor();

      // saturate up
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 5, 1);
      cyc(0, 0, 1, 5, 0, 0, 0);
      cyc(0, 0, 1, 6, 0, 0, 0);

      // saturate down then up
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 31, 0);
      for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 1, 31, 1);
      cyc(0, 0, 1, 31, 0, 0, 0);

      // read-before-write
      cyc(0, 0, 1, 9, 1, 9, 1);
      cyc(0, 0, 1, 9, 0, 0, 0);
      backdoor();

      // clear collision
      for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 1, 0, 1);
      for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 1, 17, 1);
      cyc(0, 0, 1, 0, 1, 17, 0);
      cyc(0, 1, 1, 0, 1, 17, 0);
      for (int i = 0; i < 33; i++) cyc(0, 0, 1, i % 32, 1, 17, 1);
      backdoor();

      // reset mid-INIT at pointer 20
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(20);
      cyc(1, 0, 1, 3, 0, 0, 0);
      idle(34);

      // randomized traffic with occasional clear and reset
      for (int k = 0; k < 3000; k++) begin
         bit r, c, lv, uv, ut;
         int li, ui;
         r  = ($urandom_range(0, 599) == 0);
         c  = ($urandom_range(0, 199) == 0);
         lv = $urandom_range(0, 1);
         uv = $urandom_range(0, 1);
         ut = $urandom_range(0, 1);
         li = $urandom_range(0, 7);
         ui = ($urandom_range(0, 1) == 0) ? li : $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) li = $urandom_range(0, 31);
         cyc(r, c, lv, li, uv, ui, ut);
      end
      idle(40);
      backdoor();
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bht_controller.md
# bht_controller

Controller for a 32-entry table of 2-bit saturating branch counters. The 5-bit index drives a 32:1 2-bit read mux, and the selected counter's MSB is the prediction. The block owns table initialisation, lookup sequencing and counter update for the processor's fetch stage. The decode/execute stage feeds resolved branch outcomes back through the update port.

## Interface

Parameters:
- INIT_VAL, 2'b01, value written to every counter during initialisation (weakly not-taken).

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- clear  input  1  synchronous request to re-initialise the table; honoured only in RUN.
- ready  output  1  high while in RUN; lookups and updates are accepted only when high.
- lookup_valid  input  1  lookup request this cycle.
- lookup_index  input  5  table entry to read (PC bits chosen by fetch).
- predict_valid  output  1  one-cycle pulse: the prediction for the previous cycle's lookup.
- predict_taken  output  1  MSB of the looked-up counter; held until the next accepted lookup.
- update_valid  input  1  resolved-branch update this cycle.
- update_index  input  5  entry to update.
- update_taken  input  1  actual branch outcome.

## Operation

- Storage: 32 × 2-bit counter registers. Read path: a 32:1 2-bit mux selected by lookup_index.
- States:
  - INIT: a 5-bit pointer walks 0..31, writing INIT_VAL to one entry per cycle.
  - RUN: normal operation.
- Transitions:
  - reset → INIT with pointer = 0, from any state.
  - INIT → RUN after the edge that writes entry 31.
  - RUN → INIT when clear=1; pointer reset to 0.
- INIT:
  - ready=0.
  - lookup_valid and update_valid are ignored, and the updates are dropped.
  - predict_valid=0.
- RUN lookup: when lookup_valid=1, register predict_taken ← counter[lookup_index][1] and set predict_valid=1 for one cycle.
- RUN update: when update_valid=1, counter[update_index] changes as follows:
  - +1 if update_taken=1, saturating at 2'b11.
  - −1 if update_taken=0, saturating at 2'b00.
- Update arithmetic is 2-bit unsigned with explicit saturation and no wrap. 11+taken stays 11; 00+not-taken stays 00.
- Simultaneous lookup and update to the same index: the lookup returns the counter value before the update (read-before-write). The update still commits.
- Simultaneous lookup and update to different indices: both are performed independently.
- clear with lookup_valid or update_valid in the same cycle:
  - clear wins.
  - The update is dropped.
  - No predict_valid pulse.
- reset overrides clear and all requests.
- Reset mid-INIT restarts the walk at entry 0.

## Timing

- Reset values:
  - ready=0.
  - predict_valid=0.
  - predict_taken=0.
  - state=INIT, pointer=0.
  - Counter contents are don't-care until rewritten by INIT.
- Init duration: 32 cycles. ready rises after the 32nd rising edge with reset=0 and clear=0, i.e. in cycle 33.
- Lookup latency: 1 cycle. A request sampled at edge N gives predict_valid/predict_taken valid after edge N. predict_valid drops after edge N+1 unless another lookup is sampled there.
- Update latency: 1 cycle. A counter written at edge N is visible to a lookup sampled at edge N+1.
- clear sampled at edge N: ready=0 after edge N, and ready=1 again 32 edges later.
- Throughput: one lookup and one update per cycle, no stalls in RUN.

## Test plan

- **Reset and init:** assert reset 2 cycles, release, and drive lookups during INIT → ready=0 for exactly 32 cycles, predict_valid never pulses, then ready=1. A lookup of every index returns predict_taken=0, and a backdoor read of every counter gives 2'b01.
- **Saturate up:** 3× update(index 5, taken) → counter 01→10→11→11. Lookup 5 gives predict_taken=1. Lookup 6 gives 0.
- **Saturate down:** 3× update(index 31, not-taken) → 01→00→00. Then 2× taken → 10. Lookup 31 gives 1.
- **Read-before-write:**
  - Entry 9 = 01. Same cycle: lookup 9 and update(9, taken) → predict_taken=0.
  - Next-cycle lookup 9 → predict_taken=1.
- **Clear collision:** in RUN, set entries 0 and 17 to 11. Assert clear together with update(17, not-taken) and lookup 0 →
  - no predict_valid pulse;
  - ready low for 32 cycles;
  - afterwards all counters are 01.
- **Reset mid-INIT:** assert reset at pointer=20 → walk restarts, and ready rises exactly 32 cycles after release.
